epidemic_run_ctrl: RTL and testbench

- Run controller for the agent grid.
- Loads a seed infection pattern and advances the grid one generation at a time.
- Emits one population record per generation (count of infected agents plus step index) over a valid/ready stream.
- The grid has no enable input, so the controller freezes it by holding its load input with the grid's own current state. This lets a slow stats consumer back-pressure the simulation.

---
 rtl/epidemic_run_ctrl.sv | 170 +++++++++++++++++
 tb/tb_epidemic_run_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/epidemic_run_ctrl.sv
// Run controller for the agent grid: seeds the grid, steps it one generation at a
// time and streams one population record per generation over valid/ready.
module epidemic_run_ctrl #(
    parameter int N_AGENTS = 4,
    parameter int STEP_W   = 16,
    parameter int CNT_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [N_AGENTS-1:0] cfg_seed,
    input  logic [STEP_W-1:0]   cfg_steps,
    output logic                busy,
    output logic                done,
    input  logic [N_AGENTS-1:0] grid_states,
    output logic [N_AGENTS-1:0] grid_init,
    output logic                grid_load,
    output logic                stat_valid,
    input  logic                stat_ready,
    output logic [CNT_W-1:0]    stat_count,
    output logic [STEP_W-1:0]   stat_step
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_REPORT  = 3'd3,
        ST_STEP    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [N_AGENTS-1:0] seed_r;
    logic [STEP_W-1:0]   steps_r;
    logic [N_AGENTS-1:0] snap_r;
    logic [STEP_W-1:0]   step_idx_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                busy_r;
    logic                done_r;
    logic                stat_valid_r;
    logic                grid_load_r;
    logic [N_AGENTS-1:0] grid_init_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_AGENTS-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < N_AGENTS; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Next-state decode; abort wins over every other condition outside IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (stat_ready) begin
                    // Compare before incrementing so a full-range step count never wraps.
                    if (step_idx_r == steps_r) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_STEP;
                    end
                end else begin
                    state_nx_s = ST_REPORT;
                end
            end
            ST_STEP: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register and state-decoded control outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            stat_valid_r <= 1'b0;
            grid_load_r  <= 1'b1;
        end else begin
            state_r      <= state_nx_s;
            busy_r       <= (state_nx_s != ST_IDLE);
            done_r       <= (state_nx_s == ST_DONE);
            stat_valid_r <= (state_nx_s == ST_REPORT);
            grid_load_r  <= (state_nx_s != ST_STEP);
        end
    end

    // Configuration latch, generation snapshot, population count and step index.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_r     <= {N_AGENTS{1'b0}};
            steps_r    <= {STEP_W{1'b0}};
            snap_r     <= {N_AGENTS{1'b0}};
            step_idx_r <= {STEP_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            if ((state_r == ST_IDLE) && (state_nx_s == ST_LOAD)) begin
                seed_r     <= cfg_seed;
                steps_r    <= cfg_steps;
                step_idx_r <= {STEP_W{1'b0}};
            end
            if ((state_r == ST_CAPTURE) && (state_nx_s == ST_REPORT)) begin
                snap_r <= grid_states;
                cnt_r  <= popcount(grid_states);
            end
            if ((state_r == ST_STEP) && (state_nx_s == ST_CAPTURE)) begin
                step_idx_r <= step_idx_r + {{(STEP_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Grid freeze value: CAPTURE feeds the grid its own state back so it holds.
    always_comb begin
        grid_init_s = snap_r;
        case (state_r)
            ST_LOAD:    grid_init_s = seed_r;
            ST_CAPTURE: grid_init_s = grid_states;
            default:    grid_init_s = snap_r;
        endcase
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign stat_valid = stat_valid_r;
    assign grid_load  = grid_load_r;
    assign grid_init  = grid_init_s;
    assign stat_count = cnt_r;
    assign stat_step  = step_idx_r;

endmodule

// File: tb/tb_epidemic_run_ctrl.sv
// Self-checking bench for epidemic_run_ctrl with a behavioural grid stub
// (next = s | rotl(s,1)) and a generation-sequence reference model.
module tb_epidemic_run_ctrl;

    localparam int N  = 4;
    localparam int SW = 16;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [N-1:0]  cfg_seed;
    logic [SW-1:0] cfg_steps;
    logic          busy;
    logic          done;
    logic [N-1:0]  grid_states;
    logic [N-1:0]  grid_init;
    logic          grid_load;
    logic          stat_valid;
    logic          stat_ready;
    logic [CW-1:0] stat_count;
    logic [SW-1:0] stat_step;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    epidemic_run_ctrl #(.N_AGENTS(N), .STEP_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_seed(cfg_seed), .cfg_steps(cfg_steps),
        .busy(busy), .done(done),
        .grid_states(grid_states), .grid_init(grid_init), .grid_load(grid_load),
        .stat_valid(stat_valid), .stat_ready(stat_ready),
        .stat_count(stat_count), .stat_step(stat_step)
    );

    // Grid stub
    logic [N-1:0] grid_s = 4'b0000;
    always_ff @(posedge clk) begin
        if (grid_load) grid_s <= grid_init;
        else           grid_s <= grid_s | {grid_s[N-2:0], grid_s[N-1]};
    end
    assign grid_states = grid_s;

    // Reference: grid contents after k generations from seed.
    function automatic logic [3:0] gen(input logic [3:0] seed, input int k);
        int g;
        g = int'(seed);
        for (int i = 0; i < k; i++) g = (g | (g << 1) | (g >> 3)) & 15;
        return g[3:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; stat_ready = 1'b0;
        cfg_seed = 4'b0000; cfg_steps = 16'd0;
        tick(); tick();
        vectors++;
        if (grid_load !== 1'b1 || grid_init !== 4'b0000 || busy !== 1'b0 || stat_valid !== 1'b0 ||
            done !== 1'b0 || stat_count !== 3'd0 || stat_step !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: load=%b init=%b busy=%b valid=%b done=%b cnt=%0d step=%0d, required 1 0000 0 0 0 0 0",
                     grid_load, grid_init, busy, stat_valid, done, stat_count, stat_step);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (grid_states !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_grid: grid=%b busy=%b, required 0000 0", grid_states, busy);
        end
    endtask

    // One full run; hold_k/hold_n withhold ready for hold_n cycles on record hold_k.
    task automatic run_scenario(input logic [3:0] seed, input int steps, input int pct,
                                input int hold_k, input int hold_n);
        int k, c, last_hs, held;
        logic fin, rdy;
        logic [3:0] g;
        cfg_seed = seed; cfg_steps = steps[15:0]; start = 1'b1; stat_ready = 1'b0;
        tick();
        start = 1'b0;
        c = 1; k = 0; last_hs = -10; held = 0; fin = 1'b0;
        while (!fin && c < 3000) begin
            g = gen(seed, k);
            if (done === 1'b1) begin
                vectors++;
                if (k != steps + 1 || c != last_hs + 1) begin
                    miscompares++;
                    $display("FAIL done_timing: records=%0d at cycle %0d, required records=%0d at cycle %0d",
                             k, c, steps + 1, last_hs + 1);
                end
                fin = 1'b1;
                rdy = 1'b0;
            end else begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_in_run: busy=%b at cycle %0d, required 1", busy, c);
                end
                if (stat_valid === 1'b1) begin
                    vectors++;
                    if (stat_count !== CW'($countones(g)) || stat_step !== SW'(k) || grid_states !== g) begin
                        miscompares++;
                        $display("FAIL record: count=%0d step=%0d grid=%b, required count=%0d step=%0d grid=%b",
                                 stat_count, stat_step, grid_states, $countones(g), k, g);
                    end
                    if (k == hold_k && held < hold_n) begin
                        rdy = 1'b0;
                        held++;
                    end else begin
                        rdy = ($urandom_range(1, 100) <= pct);
                    end
                    if (rdy) begin
                        if (pct == 100 && hold_n == 0) begin
                            vectors++;
                            if (c != 3 + 3 * k) begin
                                miscompares++;
                                $display("FAIL record_timing: record %0d at cycle %0d, required cycle %0d",
                                         k, c, 3 + 3 * k);
                            end
                        end
                        last_hs = c;
                        k++;
                    end
                end else begin
                    rdy = ($urandom_range(0, 1) == 1);
                end
            end
            stat_ready = rdy;
            if (!fin) begin
                tick();
                c++;
            end
        end
        stat_ready = 1'b0;
        if (!fin) begin
            miscompares++;
            $display("FAIL run_timeout: no done after %0d cycles, required done", c);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || stat_valid !== 1'b0 || grid_states !== gen(seed, steps)) begin
                miscompares++;
                $display("FAIL after_run: busy=%b done=%b valid=%b grid=%b, required 0 0 0 %b",
                         busy, done, stat_valid, grid_states, gen(seed, steps));
            end
        end
    endtask

    task automatic test_basic();
        run_scenario(4'b0001, 3, 100, -1, 0);
    endtask

    task automatic test_zero_steps();
        run_scenario(4'b1010, 0, 100, -1, 0);
    endtask

    task automatic test_back_pressure();
        run_scenario(4'b0001, 2, 100, 1, 10);
    endtask

    task automatic test_abort();
        int n;
        cfg_seed = 4'b0001; cfg_steps = 16'd5; start = 1'b1;
        tick();
        start = 1'b0; stat_ready = 1'b1; n = 0;
        while (!(stat_valid === 1'b1 && stat_step === 16'd1) && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 50) begin
            miscompares++;
            $display("FAIL abort_wait: record step 1 not seen in %0d cycles, required seen", n);
        end
        tick();
        stat_ready = 1'b0;
        vectors++;
        if (grid_load !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_step_state: grid_load=%b, required 0", grid_load);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || stat_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: busy=%b valid=%b done=%b, required 0 0 0", busy, stat_valid, done);
        end
        tick();
        vectors++;
        if (grid_states !== 4'b0011 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_revert: grid=%b done=%b, required 0011 0", grid_states, done);
        end
        start = 1'b1; abort = 1'b1; cfg_seed = 4'b1111;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || grid_states !== 4'b0011) begin
            miscompares++;
            $display("FAIL abort_blocks_start: busy=%b grid=%b, required 0 0011", busy, grid_states);
        end
        run_scenario(4'b1000, 1, 100, -1, 0);
    endtask

    task automatic test_busy_start_rst();
        int n;
        cfg_seed = 4'b0001; cfg_steps = 16'd3; start = 1'b1; stat_ready = 1'b0;
        tick();
        start = 1'b0; n = 0;
        while (stat_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        cfg_seed = 4'b1111; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (stat_valid !== 1'b1 || stat_step !== 16'd0 || stat_count !== 3'd1 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL start_ignored: valid=%b step=%0d count=%0d busy=%b, required 1 0 1 1",
                         stat_valid, stat_step, stat_count, busy);
            end
            tick();
        end
        stat_ready = 1'b1;
        tick();
        stat_ready = 1'b0;
        vectors++;
        if (grid_load !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_step_state: grid_load=%b, required 0", grid_load);
        end
        tick();
        vectors++;
        if (busy !== 1'b1 || stat_valid !== 1'b0 || grid_load !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_capture_state: busy=%b valid=%b load=%b, required 1 0 1", busy, stat_valid, grid_load);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || stat_valid !== 1'b0 || done !== 1'b0 || grid_init !== 4'b0000 || grid_load !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_midrun: busy=%b valid=%b done=%b init=%b load=%b, required 0 0 0 0000 1",
                     busy, stat_valid, done, grid_init, grid_load);
        end
        tick();
        vectors++;
        if (grid_states !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_grid_clear: grid=%b, required 0000", grid_states);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            run_scenario(4'($urandom_range(0, 15)), $urandom_range(0, 6),
                         (r % 3 == 0) ? 100 : $urandom_range(30, 90), -1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_steps();
        test_back_pressure();
        test_abort();
        test_busy_start_rst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
